// File: rtl/sram_fifo_rr_scheduler.sv
// sram_fifo_rr_scheduler: packet-atomic round-robin arbiter merging NUM_QUEUES AXI4-Stream
// queues onto one master port, with per-queue forwarded-packet counters.
module sram_fifo_rr_scheduler #(
  parameter int NUM_QUEUES     = 4,
  parameter int QUEUE_ID_WIDTH = 2,
  parameter int TDATA_WIDTH    = 32,
  parameter int TUSER_WIDTH    = 128
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic [NUM_QUEUES-1:0]               s_tvalid,
  output logic [NUM_QUEUES-1:0]               s_tready,
  input  logic [NUM_QUEUES*8*TDATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_QUEUES*TDATA_WIDTH-1:0]   s_tstrb,
  input  logic [NUM_QUEUES-1:0]               s_tlast,
  input  logic [NUM_QUEUES*TUSER_WIDTH-1:0]   s_tuser,
  output logic                                m_tvalid,
  output logic [8*TDATA_WIDTH-1:0]            m_tdata,
  output logic [TDATA_WIDTH-1:0]              m_tstrb,
  output logic                                m_tlast,
  output logic [TUSER_WIDTH-1:0]              m_tuser,
  input  logic                                m_tready,
  output logic [QUEUE_ID_WIDTH-1:0]           m_tdest,
  input  logic [NUM_QUEUES-1:0]               queue_en,
  output logic [NUM_QUEUES*32-1:0]            pkt_cnt,
  output logic                                busy
);
  localparam int DW = 8*TDATA_WIDTH;
  typedef enum logic {IDLE, XFER} state_t;
  state_t state_q, state_d;
  logic [QUEUE_ID_WIDTH-1:0] grant_q, grant_d, last_grant_q, last_grant_d, pick, idx;
  logic [NUM_QUEUES-1:0] elig;
  logic xfer, done, found;
  assign xfer = state_q == XFER;
  assign done = m_tvalid & m_tready & m_tlast;
  assign busy = xfer;
  assign elig = s_tvalid & queue_en;
  // rotating priority search starting just after the previous winner
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_QUEUES; i++) begin
      idx = QUEUE_ID_WIDTH'((int'(last_grant_q) + i) % NUM_QUEUES);
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end
  always_comb begin
    m_tvalid = xfer & s_tvalid[grant_q];
    m_tdata  = xfer ? s_tdata[int'(grant_q)*DW +: DW] : '0;
    m_tstrb  = xfer ? s_tstrb[int'(grant_q)*TDATA_WIDTH +: TDATA_WIDTH] : '0;
    m_tlast  = xfer & s_tlast[grant_q];
    m_tuser  = xfer ? s_tuser[int'(grant_q)*TUSER_WIDTH +: TUSER_WIDTH] : '0;
    m_tdest  = xfer ? grant_q : '0;
    s_tready = '0;
    s_tready[grant_q] = xfer & m_tready;
  end
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    if (!xfer && found) begin
      state_d = XFER;
      grant_d = pick;
    end
    if (done) begin
      state_d      = IDLE;
      last_grant_d = grant_q;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= QUEUE_ID_WIDTH'(NUM_QUEUES-1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end
  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_cnt
    logic [31:0] cnt_q, cnt_d;
    assign cnt_d = cnt_q + {31'd0, done && grant_q == QUEUE_ID_WIDTH'(q)};
    assign pkt_cnt[q*32 +: 32] = cnt_q;
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) cnt_q <= '0;
      else cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_sram_fifo_rr_scheduler.sv
// tb_sram_fifo_rr_scheduler: directed stimulus with a queue-based reference model checked
// every cycle, plus literal expectations for the arbitration scenarios.
module tb_sram_fifo_rr_scheduler;
  logic clk = 1'b0;
  logic resetn;
  logic [3:0] s_tvalid, s_tready, s_tlast, queue_en;
  logic [1023:0] s_tdata;
  logic [127:0] s_tstrb;
  logic [511:0] s_tuser;
  logic m_tvalid, m_tlast, m_tready, busy;
  logic [255:0] m_tdata;
  logic [31:0] m_tstrb;
  logic [127:0] m_tuser, pkt_cnt;
  logic [1:0] m_tdest;

  sram_fifo_rr_scheduler dut (
    .clk(clk), .resetn(resetn), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tstrb(s_tstrb), .s_tlast(s_tlast), .s_tuser(s_tuser), .m_tvalid(m_tvalid),
    .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .m_tready(m_tready), .m_tdest(m_tdest), .queue_en(queue_en), .pkt_cnt(pkt_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [31:0] sw [4][$];
  bit sl [4][$];
  bit hold [4];
  int cur, last, nc, nl, inc;
  logic [31:0] mcnt [4];
  logic [31:0] base [4];
  logic [3:0] acc;
  bit lv[$], lh[$];
  int ld[$];
  logic [31:0] lw[$];
  logic [3:0] lr[$];
  int hd[$];
  logic [31:0] hw[$];

  function automatic logic [31:0] wd(int q, int p, int b);
    return 32'((q << 24) | (p << 8) | b);
  endfunction

  task automatic chk(string n, logic [255:0] got, logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", n, $time, got, exp);
    end
  endtask

  task automatic push_pkt(int q, int p, int n);
    for (int b = 0; b < n; b++) begin
      sw[q].push_back(wd(q, p, b));
      sl[q].push_back(b == n-1);
    end
  endtask

  task automatic drive();
    for (int q = 0; q < 4; q++) begin
      s_tvalid[q] = 1'b0;
      s_tlast[q]  = 1'b0;
      s_tdata[q*256 +: 256] = '0;
      s_tstrb[q*32 +: 32]   = '0;
      s_tuser[q*128 +: 128] = '0;
      if (sw[q].size() > 0) begin
        s_tvalid[q] = !hold[q];
        s_tlast[q]  = sl[q][0];
        s_tdata[q*256 +: 256] = {8{sw[q][0]}};
        s_tstrb[q*32 +: 32]   = sw[q][0] ^ 32'hA5A5A5A5;
        s_tuser[q*128 +: 128] = {4{~sw[q][0]}};
      end
    end
  endtask

  // Reference: idle cycles arbitrate, granted cycles pass one queue through until its last beat.
  task automatic eval();
    logic [3:0] esr, el;
    logic [127:0] ecnt;
    bit ev, eb;
    int ed, k;
    esr = '0; ev = 0; eb = 0; ed = 0;
    nc = cur; nl = last; inc = -1;
    for (int q = 0; q < 4; q++) ecnt[q*32 +: 32] = resetn ? base[q] + mcnt[q] : 32'd0;
    if (resetn && cur >= 0) begin
      eb = 1; ed = cur; ev = s_tvalid[cur]; esr[cur] = m_tready;
    end
    chk("m_tvalid", 256'(m_tvalid), 256'(ev));
    chk("s_tready", 256'(s_tready), 256'(esr));
    chk("m_tdest", 256'(m_tdest), 256'(ed));
    chk("busy", 256'(busy), 256'(eb));
    chk("pkt_cnt", 256'(pkt_cnt), 256'(ecnt));
    if (ev) begin
      chk("m_tdata", m_tdata, {8{sw[cur][0]}});
      chk("m_tstrb", 256'(m_tstrb), 256'(sw[cur][0] ^ 32'hA5A5A5A5));
      chk("m_tlast", 256'(m_tlast), 256'(sl[cur][0]));
      chk("m_tuser", 256'(m_tuser), 256'({4{~sw[cur][0]}}));
    end
    if (!resetn) begin
      nc = -1; nl = 3;
    end else if (cur < 0) begin
      el = s_tvalid & queue_en;
      for (int i = 1; i <= 4; i++) begin
        k = (last + i) % 4;
        if (nc < 0 && el[k]) nc = k;
      end
    end else if (ev && m_tready && sl[cur][0]) begin
      nc = -1; nl = cur; inc = cur;
    end
    acc = resetn ? (esr & s_tvalid) : 4'd0;
    if (resetn) begin
      lv.push_back(m_tvalid); ld.push_back(int'(m_tdest)); lw.push_back(m_tdata[31:0]);
      lh.push_back(m_tvalid && m_tready); lr.push_back(s_tready);
    end
  endtask

  task automatic tick();
    drive();
    @(negedge clk);
    eval();
    @(posedge clk);
    if (!resetn) begin
      cur = -1; last = 3;
      for (int q = 0; q < 4; q++) mcnt[q] = '0;
    end else begin
      cur = nc; last = nl;
      if (inc >= 0) mcnt[inc] = mcnt[inc] + 32'd1;
    end
    #1;
    for (int q = 0; q < 4; q++)
      if (acc[q]) begin
        void'(sw[q].pop_front());
        void'(sl[q].pop_front());
      end
    drive();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    for (int q = 0; q < 4; q++) begin
      sw[q].delete(); sl[q].delete(); hold[q] = 0; base[q] = '0; mcnt[q] = '0;
    end
    cur = -1; last = 3;
    queue_en = 4'hF; m_tready = 1'b1;
    tick(); tick();
    resetn = 1'b1;
  endtask

  task automatic collect(int mark);
    hd.delete(); hw.delete();
    for (int i = mark; i < lh.size(); i++)
      if (lh[i]) begin
        hd.push_back(ld[i]); hw.push_back(lw[i]);
      end
  endtask

  initial begin
    int mark, n, bad;
    int exp_d [10];
    logic [9:0] pat;
    resetn = 1'b0;
    m_tready = 1'b1;
    queue_en = 4'hF;
    for (int q = 0; q < 4; q++) begin hold[q] = 0; base[q] = '0; mcnt[q] = '0; end
    cur = -1; last = 3; acc = '0;
    drive();
    repeat (3) tick();
    chk("rst_m_tvalid", 256'(m_tvalid), 256'(0));
    chk("rst_s_tready", 256'(s_tready), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_pkt_cnt", 256'(pkt_cnt), 256'(0));
    chk("rst_m_tdest", 256'(m_tdest), 256'(0));
    resetn = 1'b1;

    // two 3-beat packets on queues 0 and 2
    mark = lv.size();
    push_pkt(0, 0, 3); push_pkt(2, 0, 3);
    repeat (10) tick();
    pat = '0;
    for (int i = 0; i < 9; i++) pat = {pat[8:0], lv[mark+i]};
    chk("a_valid_pattern", 256'(pat), 256'(10'b0011101110));
    collect(mark);
    chk("a_beats", 256'(hw.size()), 256'(6));
    for (int i = 0; i < 6; i++)
      chk("a_order", 256'(hw[i]), 256'(i < 3 ? wd(0, 0, i) : wd(2, 0, i-3)));
    chk("a_pkt_cnt", 256'(pkt_cnt), 256'({32'd0, 32'd1, 32'd0, 32'd1}));

    // all queues streaming single-beat packets
    do_reset();
    mark = lv.size();
    for (int p = 0; p < 3; p++) for (int q = 0; q < 4; q++) push_pkt(q, p, 1);
    repeat (12) tick();
    pat = '0;
    for (int i = 0; i < 10; i++) pat = {pat[8:0], lv[mark+i]};
    chk("b_valid_pattern", 256'(pat), 256'(10'b0101010101));
    collect(mark);
    for (int i = 0; i < 5; i++) chk("b_dest_seq", 256'(hd[i]), 256'(i % 4));

    // stalls inside a queue 1 packet
    do_reset();
    mark = lv.size();
    push_pkt(1, 0, 4);
    tick();
    push_pkt(0, 1, 2); push_pkt(2, 1, 2); push_pkt(3, 1, 2);
    tick();
    m_tready = 1'b0; repeat (3) tick();
    m_tready = 1'b1; tick();
    hold[1] = 1; repeat (2) tick();
    hold[1] = 0; repeat (20) tick();
    collect(mark);
    for (int i = 0; i < 4; i++) chk("c_q1_beat", 256'(hw[i]), 256'(wd(1, 0, i)));
    chk("c_next_dest", 256'(hd[4]), 256'(2));
    bad = 0; n = 0;
    for (int i = mark; i < lh.size() && n < 4; i++) begin
      if ((lr[i] & 4'b1101) != 0) bad++;
      if (lh[i]) n++;
    end
    chk("c_other_ready", 256'(bad), 256'(0));

    // queue 2 disabled, queue 1 disabled mid-packet
    do_reset();
    queue_en = 4'b1011;
    mark = lv.size();
    for (int q = 0; q < 4; q++) begin push_pkt(q, 0, 2); push_pkt(q, 1, 2); end
    n = 0;
    while (!(lv.size() > mark && lv[lv.size()-1] && ld[ld.size()-1] == 1) && n < 50) begin
      tick(); n++;
    end
    chk("d_q1_granted_in_time", 256'(n < 50), 256'(1));
    queue_en[1] = 1'b0;
    repeat (30) tick();
    collect(mark);
    exp_d = '{0, 0, 1, 1, 3, 3, 0, 0, 3, 3};
    chk("d_beats", 256'(hd.size()), 256'(10));
    for (int i = 0; i < 10; i++) chk("d_dest_seq", 256'(hd[i]), 256'(exp_d[i]));
    chk("d_q1_b0", 256'(hw[2]), 256'(wd(1, 0, 0)));
    chk("d_q1_b1", 256'(hw[3]), 256'(wd(1, 0, 1)));

    // reset in the middle of a 5-beat packet
    do_reset();
    push_pkt(0, 2, 1);
    repeat (4) tick();
    chk("e_cnt0", 256'(pkt_cnt[31:0]), 256'(1));
    push_pkt(2, 2, 5);
    tick(); tick();
    chk("e_pre_valid", 256'(m_tvalid), 256'(1));
    resetn = 1'b0;
    #1;
    chk("e_rst_valid", 256'(m_tvalid), 256'(0));
    chk("e_rst_ready", 256'(s_tready), 256'(0));
    chk("e_rst_busy", 256'(busy), 256'(0));
    chk("e_rst_cnt", 256'(pkt_cnt), 256'(0));
    do_reset();
    mark = lv.size();
    push_pkt(3, 3, 1); push_pkt(0, 3, 1);
    repeat (6) tick();
    collect(mark);
    chk("e_first_dest", 256'(hd[0]), 256'(0));
    chk("e_second_dest", 256'(hd[1]), 256'(3));

    // counter wrap on queue 3
    force dut.g_cnt[3].cnt_q = 32'hFFFFFFFE;
    base[3] = 32'hFFFFFFFE - mcnt[3];
    tick(); tick();
    release dut.g_cnt[3].cnt_q;
    tick();
    push_pkt(3, 4, 1);
    repeat (3) tick();
    chk("f_cnt3_max", 256'(pkt_cnt[127:96]), 256'(32'hFFFFFFFF));
    push_pkt(3, 5, 1);
    repeat (3) tick();
    chk("f_cnt3_wrap", 256'(pkt_cnt[127:96]), 256'(32'h00000000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
